// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and received-byte bus of the UART receiver.
//   rx    - serial data in, idle high, asynchronous to clk
//   data  - last good received byte
//   rcv   - one-cycle pulse, data has just been loaded
//   ferr  - one-cycle pulse, stop bit was sampled low
//   busy  - a frame is in progress
// master: the receiver; slave: the line driver / byte consumer.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output rcv,
        output ferr,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  rcv,
        input  ferr,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
//   clk  - system clock
//   rstn - synchronous reset, active low
//   bus  - uart_rx_if.master: rx in; data, rcv, ferr, busy out (all registered)
// BAUD is the number of clk cycles per bit period.
module uart_rx #(
    parameter int unsigned BAUD = 104
) (
    input  logic       clk,
    input  logic       rstn,
    uart_rx_if.master  bus
);

    localparam int unsigned CNT_W   = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       sync;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [2:0]       idx;
    logic [2:0]       idx_nx;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nx;
    logic [7:0]       data_nx;
    logic             rcv_nx;
    logic             ferr_nx;
    logic             half_evt;
    logic             full_evt;

    assign rx_s     = sync[1];
    assign half_evt = (cnt == HALF_M1);
    assign full_evt = (cnt == FULL_M1);

    // State, timing and output registers; sync flops idle high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync     <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            bus.data <= '0;
            bus.rcv  <= 1'b0;
            bus.ferr <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            sync     <= {sync[0], bus.rx};
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            shreg    <= shreg_nx;
            bus.data <= data_nx;
            bus.rcv  <= rcv_nx;
            bus.ferr <= ferr_nx;
            bus.busy <= (state_nx != IDLE);
        end
    end

    // Next-state and next-output logic; the counter restarts on every state entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        idx_nx   = idx;
        shreg_nx = shreg;
        data_nx  = bus.data;
        rcv_nx   = 1'b0;
        ferr_nx  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) begin
                    state_nx = START;
                end
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (half_evt) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        state_nx = DATA;
                        idx_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (full_evt) begin
                    cnt_nx   = '0;
                    shreg_nx = {rx_s, shreg[7:1]};
                    idx_nx   = idx + 3'(1);
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit guarantees the next start edge is seen.
                if (full_evt) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        data_nx  = shreg;
                        rcv_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A low line here is a break, not a new start bit.
                if (rx_s) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
